// File: rtl/alu_pkg.sv
// Shared op-code constants, FSM state type and default datapath width for seq_alu.
package alu_pkg;

  localparam int unsigned DefaultWidth = 32;

  localparam logic [4:0] OpAdd   = 5'h00;
  localparam logic [4:0] OpAddu  = 5'h01;
  localparam logic [4:0] OpSub   = 5'h02;
  localparam logic [4:0] OpSubu  = 5'h03;
  localparam logic [4:0] OpAnd   = 5'h04;
  localparam logic [4:0] OpOr    = 5'h05;
  localparam logic [4:0] OpXor   = 5'h06;
  localparam logic [4:0] OpXnor  = 5'h07;
  localparam logic [4:0] OpSlt   = 5'h08;
  localparam logic [4:0] OpSltu  = 5'h09;
  localparam logic [4:0] OpSll   = 5'h0A;
  localparam logic [4:0] OpSrl   = 5'h0B;
  localparam logic [4:0] OpSra   = 5'h0C;
  localparam logic [4:0] OpBeq   = 5'h0D;
  localparam logic [4:0] OpBne   = 5'h0E;
  localparam logic [4:0] OpLui   = 5'h0F;
  localparam logic [4:0] OpMul   = 5'h10;
  localparam logic [4:0] OpMulhu = 5'h11;
  localparam logic [4:0] OpDivu  = 5'h12;
  localparam logic [4:0] OpRemu  = 5'h13;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_t;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative shift-add multiplier and (with SEQ_ALU_DIV_EN) restoring divider, one bit per cycle.
module seq_alu_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_hi,
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  localparam int unsigned CW = $clog2(WIDTH);

  // r_acc is {hi, lo}: {partial product, multiplier} or {remainder, quotient}.
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_acc_d;
  logic [WIDTH-1:0]   r_b;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_hi;
  logic               r_div;
  logic [WIDTH:0]     w_add;

`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH:0] w_sub;
`else
  logic w_unused_div;
  assign w_unused_div = r_div;
`endif

  always_comb begin
    w_add   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    w_acc_d = {w_add, r_acc[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
    // Borrow out of the trial subtraction means the shifted remainder stays.
    w_sub = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_b};
    if (r_div) begin
      w_acc_d = w_sub[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                             : {w_sub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc  <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_hi   <= 1'b0;
      r_div  <= 1'b0;
    end else if (i_start) begin
      r_acc  <= {{WIDTH{1'b0}}, i_a};
      r_b    <= i_b;
      r_cnt  <= '0;
      r_busy <= 1'b1;
      r_hi   <= i_hi;
      r_div  <= i_div;
    end else if (r_busy) begin
      r_acc <= w_acc_d;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CW'(WIDTH - 1)) r_busy <= 1'b0;
    end
  end

  // Done and result are presented during the last iteration so the caller latches on that edge.
  assign o_busy   = r_busy;
  assign o_done   = r_busy && (r_cnt == CW'(WIDTH - 1));
  assign o_result = r_hi ? w_acc_d[2*WIDTH-1:WIDTH] : w_acc_d[WIDTH-1:0];

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshake; DIVU/REMU are built only when SEQ_ALU_DIV_EN is defined.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             ovf,
  output logic             illegal
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_state_d;
  logic [WIDTH-1:0] r_out;
  logic             r_zero;
  logic             r_ovf;
  logic             r_illegal;

  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [SHW-1:0]   w_sh;
  logic             w_zero;
  logic             w_ovf;
  logic             w_illegal;
  logic             w_multi;
  logic             w_accept;
  logic             w_md_done;
  logic             w_unused_md_busy;
  logic [WIDTH-1:0] w_md_result;

  assign w_sum  = A + B;
  assign w_diff = A - B;
  assign w_sh   = A[SHW-1:0];

  always_comb begin
    w_res     = '0;
    w_zero    = 1'b0;
    w_ovf     = 1'b0;
    w_illegal = 1'b0;
    w_multi   = 1'b0;
    case (op)
      OpAdd: begin
        w_res = w_sum;
        w_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OpAddu: w_res = w_sum;
      OpSub: begin
        w_res = w_diff;
        w_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
      end
      OpSubu:  w_res = w_diff;
      OpAnd:   w_res = A & B;
      OpOr:    w_res = A | B;
      OpXor:   w_res = A ^ B;
      OpXnor:  w_res = ~(A ^ B);
      OpSlt:   w_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OpSltu:  w_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OpSll:   w_res = B << w_sh;
      OpSrl:   w_res = B >> w_sh;
      OpSra:   w_res = $signed(B) >>> w_sh;
      OpBeq:   w_zero = (A == B);
      OpBne:   w_zero = (A != B);
      OpLui:   w_res = B << (WIDTH / 2);
      OpMul, OpMulhu: w_multi = 1'b1;
`ifdef SEQ_ALU_DIV_EN
      OpDivu, OpRemu: w_multi = 1'b1;
`endif
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_accept = in_valid && (r_state == StIdle);

  seq_alu_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (w_accept && w_multi),
    .i_hi    ((op == OpMulhu) || (op == OpRemu)),
    .i_div   ((op == OpDivu) || (op == OpRemu)),
    .i_a     (A),
    .i_b     (B),
    .o_busy  (w_unused_md_busy),
    .o_done  (w_md_done),
    .o_result(w_md_result)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (in_valid) w_state_d = w_multi ? StBusy : StDone;
      StBusy:  if (w_md_done) w_state_d = StDone;
      StDone:  if (out_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Result registers only load in IDLE/BUSY, so outputs hold steady for the whole DONE phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_out     <= '0;
      r_zero    <= 1'b0;
      r_ovf     <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept && !w_multi) begin
        r_out     <= w_res;
        r_zero    <= w_zero;
        r_ovf     <= w_ovf;
        r_illegal <= w_illegal;
      end else if ((r_state == StBusy) && w_md_done) begin
        r_out     <= w_md_result;
        r_zero    <= 1'b0;
        r_ovf     <= 1'b0;
        r_illegal <= 1'b0;
      end
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign out       = r_out;
  assign zero      = r_zero;
  assign ovf       = r_ovf;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_seq_alu.sv
// Table-driven scoreboard bench for seq_alu (WIDTH=32); expectations follow SEQ_ALU_DIV_EN.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         zero;
  logic         ovf;
  logic         illegal;

  always #5 clk = ~clk;

  seq_alu #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .A        (a),
    .B        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .zero     (zero),
    .ovf      (ovf),
    .illegal  (illegal)
  );

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] out;
    logic         chk_out;
    logic         zero;
    logic         ovf;
    logic         ill;
    int           lat;
    int           hold;
  } vec_t;

  typedef struct {
    logic [W-1:0] out;
    logic         chk_out;
    logic         zero;
    logic         ovf;
    logic         ill;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [4:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W-1:0] vout, input logic chk, input logic vz,
                         input logic vo, input logic vi, input int lat, input int hold);
    vec_t v;
    v.op = o; v.a = va; v.b = vb; v.out = vout; v.chk_out = chk;
    v.zero = vz; v.ovf = vo; v.ill = vi; v.lat = lat; v.hold = hold;
    vecs.push_back(v);
  endtask

  task automatic do_op(input vec_t v);
    int   n;
    int   lat;
    bit   rdy_seen;
    exp_t e;
    string tag;
    tag = $sformatf("op%02h a=%0h b=%0h", v.op, v.a, v.b);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check({tag, " in_ready_wait"}, 0, 1);
      return;
    end
    in_valid = 1'b1; op = v.op; a = v.a; b = v.b;
    e.out = v.out; e.chk_out = v.chk_out; e.zero = v.zero; e.ovf = v.ovf; e.ill = v.ill;
    sb_q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    rdy_seen = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (in_ready) rdy_seen = 1'b1;
    end while (!out_valid && lat < 200);
    check({tag, " latency"}, lat, v.lat);
    check({tag, " in_ready_low"}, rdy_seen, 0);
    if (!out_valid) return;
    e = sb_q.pop_front();
    for (int h = 0; h <= v.hold; h++) begin
      if (h > 0) begin
        @(negedge clk);
        check({tag, " hold_out_valid"}, out_valid, 1);
        check({tag, " hold_in_ready"}, in_ready, 0);
      end
      if (e.chk_out) check({tag, " out"}, out, e.out);
      check({tag, " zero"}, zero, e.zero);
      check({tag, " ovf"}, ovf, e.ovf);
      check({tag, " illegal"}, illegal, e.ill);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, " out_valid_drop"}, out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit   seen_valid;
    vec_t v;
    int   ml = W + 1;

    add_vec(OpAdd,   32'h7FFFFFFF, 32'h1,        32'h80000000, 1, 0, 1, 0, 1,  0);
    add_vec(OpAdd,   32'd5,        32'd3,        32'd8,        1, 0, 0, 0, 1,  0);
    add_vec(OpAddu,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1, 0, 0, 0, 1,  0);
    add_vec(OpSub,   32'h80000000, 32'h1,        32'h7FFFFFFF, 1, 0, 1, 0, 1,  0);
    add_vec(OpSubu,  32'd3,        32'd5,        32'hFFFFFFFE, 1, 0, 0, 0, 1,  0);
    add_vec(OpAnd,   32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1, 0, 0, 0, 1,  0);
    add_vec(OpOr,    32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1, 0, 0, 0, 1,  0);
    add_vec(OpXor,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1, 0, 0, 0, 1,  0);
    add_vec(OpXnor,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF00FF00F, 1, 0, 0, 0, 1,  0);
    add_vec(OpSlt,   32'hFFFFFFFF, 32'h1,        32'h1,        1, 0, 0, 0, 1,  0);
    add_vec(OpSltu,  32'hFFFFFFFF, 32'h1,        32'h0,        1, 0, 0, 0, 1,  5);
    add_vec(OpSll,   32'd4,        32'h1,        32'h10,       1, 0, 0, 0, 1,  0);
    add_vec(OpSll,   32'h24,       32'h1,        32'h10,       1, 0, 0, 0, 1,  0);
    add_vec(OpSrl,   32'd4,        32'h80000000, 32'h08000000, 1, 0, 0, 0, 1,  0);
    add_vec(OpSra,   32'd4,        32'h80000000, 32'hF8000000, 1, 0, 0, 0, 1,  0);
    add_vec(OpBeq,   32'd5,        32'd5,        32'h0,        0, 1, 0, 0, 1,  0);
    add_vec(OpBne,   32'd5,        32'd5,        32'h0,        0, 0, 0, 0, 1,  0);
    add_vec(OpBne,   32'd5,        32'd6,        32'h0,        0, 1, 0, 0, 1,  0);
    add_vec(OpLui,   32'h0,        32'h1234,     32'h12340000, 1, 0, 0, 0, 1,  0);
    add_vec(OpMul,   32'h12345678, 32'h10,       32'h23456780, 1, 0, 0, 0, ml, 0);
    add_vec(OpMul,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        1, 0, 0, 0, ml, 0);
    add_vec(OpMulhu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1, 0, 0, 0, ml, 2);
    add_vec(5'h14,   32'd1,        32'd2,        32'h0,        1, 0, 0, 1, 1,  0);
    add_vec(5'h1F,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1, 0, 0, 1, 1,  0);
`ifdef SEQ_ALU_DIV_EN
    add_vec(OpDivu,  32'd100,      32'd0,        32'hFFFFFFFF, 1, 0, 0, 0, ml, 0);
    add_vec(OpRemu,  32'd100,      32'd0,        32'd100,      1, 0, 0, 0, ml, 0);
    add_vec(OpDivu,  32'd100,      32'd7,        32'd14,       1, 0, 0, 0, ml, 0);
    add_vec(OpRemu,  32'd100,      32'd7,        32'd2,        1, 0, 0, 0, ml, 0);
`else
    add_vec(OpDivu,  32'd100,      32'd7,        32'h0,        1, 0, 0, 1, 1,  0);
    add_vec(OpRemu,  32'd100,      32'd0,        32'h0,        1, 0, 0, 1, 1,  0);
`endif

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset out", out, 0);
    check("reset out_valid", out_valid, 0);
    check("reset flags", {zero, ovf, illegal}, 0);
    rst = 1'b0;
    #1 check("in_ready after reset", in_ready, 1);

    foreach (vecs[i]) do_op(vecs[i]);

    // Abort a multiply mid-flight; nothing may come out afterwards.
    @(negedge clk);
    in_valid = 1'b1; op = OpMul; a = 32'd9; b = 32'd9;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 check("abort in_ready", in_ready, 1);
    seen_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    check("abort no out_valid", seen_valid, 0);
    v.op = OpAdd; v.a = 32'd2; v.b = 32'd3; v.out = 32'd5; v.chk_out = 1'b1;
    v.zero = 1'b0; v.ovf = 1'b0; v.ill = 1'b0; v.lat = 1; v.hold = 0;
    do_op(v);

    check("scoreboard empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
